uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer between the uart core and the io block.
//  - Captures each byte the uart delivers (rx_data qualified by rx_done).
//  - Holds up to DEPTH bytes so CPU polling latency does not drop traffic.
//  - Presents the head byte first-word-fall-through to the io read path.
//  - Status outputs: empty/full/count plus a sticky overrun flag.
// PARAMETERS
//  DEPTH  16  entries; power of 2, range 2..256
//  AW     4   log2(DEPTH); pointer width; count is AW+1 bits
// PORTS
//  clk          in   1     system clock (CLOCK_50 domain, same as cpu/uart)
//  rst          in   1     asynchronous reset, active-high
//  rx_data      in   8     byte from uart receiver
//  rx_done      in   1     write strobe; each high cycle pushes one byte
//  rd           in   1     pop strobe from io; one pop per high cycle
//  rd_data      out  8     head byte, valid while empty==0
//  empty        out  1     no bytes stored
//  full         out  1     count==DEPTH
//  count        out  AW+1  bytes stored, 0..DEPTH
//  overrun      out  1     sticky: a byte was dropped because FIFO was full
//  clr_overrun  in   1     clears overrun
//  thresh       in   AW+1  irq level (ports exist only with macro, see below)
//  irq          out  1     level irq (ports exist only with macro, see below)
// BEHAVIOUR
//  Reset (async assert, sync release): wr_ptr=rd_ptr=0; count=0; empty=1;
//   full=0; overrun=0; irq=0. Memory contents are not reset; rd_data is
//   don't-care while empty.
//  Storage: DEPTH x 8 register array; pointers are AW bits and wrap modulo
//   DEPTH (DEPTH-1 -> 0). count is a separate registered counter.
//   empty, full and irq are registered and update in the same edge as count.
//  Write: rx_done=1 and (full=0 or rd=1) -> mem[wr_ptr]<=rx_data;
//   wr_ptr++ at the same edge.
//  Read: rd=1 and empty=0 -> rd_ptr++ at the next edge; rd_data is
//   combinational mem[rd_ptr], so the next byte shows 0 cycles after the pop.
//  Latency: a byte written at edge N is visible on rd_data (empty=0) after
//   edge N.
//  Count: +1 on write only; -1 on pop only; unchanged on both or neither.
//  Boundary conditions:
//  - rd while empty: ignored; pointers and count are unchanged. This is
//    not an error.
//  - rx_done while full, rd=0: byte dropped; overrun<=1; FIFO unchanged.
//  - rx_done and rd together while full: pop and write both happen;
//    count stays DEPTH; no overrun.
//  - rx_done and rd together while empty: write happens, pop is ignored;
//    count becomes 1.
//  - clr_overrun and a new drop in the same cycle: set wins; overrun=1.
//  - rst mid-burst: all state clears immediately; bytes in flight are lost.
//  rx_done is a 1-cycle pulse from the uart. If it is held high, the block
//   pushes on every cycle; no edge detection is performed.
// CONFIGURATION
//  Macro UART_RX_FIFO_IRQ_EN.
//  Defined: thresh and irq ports exist. irq is registered and is set when
//   the next count is >= thresh and thresh != 0. irq clears as soon as
//   count drops below thresh. thresh=0 disables irq.
//  Undefined: thresh and irq ports are absent; no related logic is built.
//   All other behaviour is identical.
// TESTING
//  1. Reset, then push 0x41,0x42,0x43 -> count=3, rd_data=0x41; 3 pops
//     return 41,42,43 in order; empty=1 after the 3rd pop.
//  2. Push 16 bytes 0x00..0x0F -> full=1, count=16. Push 0xAA -> overrun=1,
//     0xAA not stored. Pop all -> 00..0F returned; assert clr_overrun ->
//     overrun=0.
//  3. Full FIFO, rx_done=1 and rd=1 in the same cycle with 0x55 ->
//     count=16, overrun=0. After 15 pops, rd_data=0x55.
//  4. Empty FIFO, rd=1 alone -> count=0, ptrs unchanged. rx_done=1 (0x77)
//     and rd=1 together -> count=1, rd_data=0x77.
//  5. Wrap: 40 rounds of push-3/pop-3 with an incrementing pattern -> data
//     matches the scoreboard across pointer wrap; count ends at 0.
//  6. Macro defined, thresh=4: after 3 pushes irq=0; after the 4th push
//     irq=1; after 1 pop irq=0. Assert rst mid-test -> irq=0, count=0,
//     empty=1 immediately.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus between uart/io side (master) and the rx byte FIFO (slave).
// thresh/irq exist only when UART_RX_FIFO_IRQ_EN is defined.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rd;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overrun;
  logic        clr_overrun;
`ifdef UART_RX_FIFO_IRQ_EN
  logic [AW:0] thresh;
  logic        irq;

  modport master (
    output rx_data, rx_done, rd, clr_overrun, thresh,
    input  rd_data, empty, full, count, overrun, irq
  );
  modport slave (
    input  rx_data, rx_done, rd, clr_overrun, thresh,
    output rd_data, empty, full, count, overrun, irq
  );
`else
  modport master (
    output rx_data, rx_done, rd, clr_overrun,
    input  rd_data, empty, full, count, overrun
  );
  modport slave (
    input  rx_data, rx_done, rd, clr_overrun,
    output rd_data, empty, full, count, overrun
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO, first-word-fall-through (write visible after 1 edge); no backpressure to
// the uart: a push into a full FIFO without a same-cycle pop is dropped and sets sticky overrun. Optional irq: UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          empty_q;
  logic          full_q;
  logic          overrun_q;
  logic          do_wr;
  logic          do_rd;
  logic          drop;

  assign do_rd = bus.rd && !empty_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_wr = bus.rx_done && (!full_q || bus.rd);
  assign drop  = bus.rx_done && full_q && !bus.rd;

  always_comb begin
    count_nxt = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count_q + (AW+1)'(1);
      2'b01:   count_nxt = count_q - (AW+1)'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == (AW+1)'(DEPTH));
      if (drop)
        overrun_q <= 1'b1;
      else if (bus.clr_overrun)
        overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rd_data = mem[rd_ptr];
  assign bus.empty   = empty_q;
  assign bus.full    = full_q;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq_q <= 1'b0;
    else
      irq_q <= (bus.thresh != '0) && (count_nxt >= bus.thresh);
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus sticky overrun flag.
  byte unsigned mq[$];
  bit           movr;
  int           mn;
  bit           mdrop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      movr = 1'b0;
    end else begin
      mn    = mq.size();
      mdrop = bus.rx_done && (mn == DEPTH) && !bus.rd;
      if (bus.rd && mn != 0) void'(mq.pop_front());
      if (bus.rx_done && !mdrop) mq.push_back(bus.rx_data);
      if (mdrop) movr = 1'b1;
      else if (bus.clr_overrun) movr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cmp_count", 32'(bus.count), 32'(mq.size()));
      chk("cmp_empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("cmp_full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("cmp_overrun", 32'(bus.overrun), 32'(movr));
      if (mq.size() != 0) chk("cmp_rd_data", 32'(bus.rd_data), 32'(mq[0]));
`ifdef UART_RX_FIFO_IRQ_EN
      chk("cmp_irq", 32'(bus.irq),
          32'((bus.thresh != 0) && (mq.size() >= int'(bus.thresh))));
`endif
    end
  end

  // One clock cycle with the given strobes; called and returns at a negedge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.rx_done     = w;
    bus.rx_data     = d;
    bus.rd          = r;
    bus.clr_overrun = c;
    @(posedge clk);
    @(negedge clk);
    bus.rx_done     = 1'b0;
    bus.rd          = 1'b0;
    bus.clr_overrun = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk(name, 32'(bus.rd_data), 32'(exp));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  logic [7:0] pat;

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus.rx_done     = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rd          = 1'b0;
    bus.clr_overrun = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
    bus.thresh = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic order
    push(8'h41); push(8'h42); push(8'h43);
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_head", 32'(bus.rd_data), 32'h41);
    pop_expect("t1_pop0", 8'h41);
    pop_expect("t1_pop1", 8'h42);
    pop_expect("t1_pop2", 8'h43);
    chk("t1_empty", 32'(bus.empty), 32'd1);

    // 2: fill, overrun, set-wins-over-clear, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd16);
    push(8'hAA);
    chk("t2_overrun", 32'(bus.overrun), 32'd1);
    chk("t2_count_drop", 32'(bus.count), 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_clr", 32'(bus.overrun), 32'd0);
    cyc(1'b1, 8'hAB, 1'b0, 1'b1);
    chk("t2_set_wins", 32'(bus.overrun), 32'd1);
    for (int i = 0; i < DEPTH; i++) pop_expect("t2_pop", 8'(i));
    chk("t2_empty", 32'(bus.empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_clr_end", 32'(bus.overrun), 32'd0);

    // 3: push+pop while full
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t3_count", 32'(bus.count), 32'd16);
    chk("t3_overrun", 32'(bus.overrun), 32'd0);
    for (int i = 1; i < DEPTH; i++) pop_expect("t3_pop", 8'(8'h10 + i));
    chk("t3_head55", 32'(bus.rd_data), 32'h55);
    pop_expect("t3_pop55", 8'h55);

    // 4: pop while empty; push+pop while empty
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_count0", 32'(bus.count), 32'd0);
    chk("t4_empty", 32'(bus.empty), 32'd1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t4_count1", 32'(bus.count), 32'd1);
    chk("t4_head77", 32'(bus.rd_data), 32'h77);
    pop_expect("t4_pop77", 8'h77);

    // 5: pointer wrap
    pat = 8'h80;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 3; k++) push(8'(pat + k));
      for (int k = 0; k < 3; k++) pop_expect("t5_pop", 8'(pat + k));
      pat = pat + 8'd3;
    end
    chk("t5_count", 32'(bus.count), 32'd0);

    // 6: irq threshold, then reset mid-burst
`ifdef UART_RX_FIFO_IRQ_EN
    bus.thresh = 5'd4;
    push(8'h01); push(8'h02); push(8'h03);
    chk("t6_irq3", 32'(bus.irq), 32'd0);
    push(8'h04);
    chk("t6_irq4", 32'(bus.irq), 32'd1);
    pop_expect("t6_pop", 8'h01);
    chk("t6_irq_pop", 32'(bus.irq), 32'd0);
    push(8'h05);
    chk("t6_irq_again", 32'(bus.irq), 32'd1);
`else
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("t6_count4", 32'(bus.count), 32'd4);
`endif
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hEE;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_full", 32'(bus.full), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("t6_rst_irq", 32'(bus.irq), 32'd0);
`endif
    bus.rx_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_count", 32'(bus.count), 32'd0);
    push(8'h99);
    chk("t6_post_head", 32'(bus.rd_data), 32'h99);
    pop_expect("t6_post_pop", 8'h99);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
